// File: rtl/xge_rx_reader_pkg.sv
// Shared types and constants for the 10G MAC receive-side reader.
package xge_pkg;

    localparam int XGE_DATA_W = 64;
    localparam int XGE_MOD_W  = 3;

    // One MAC word together with its framing, as stored in the reader FIFO.
    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic                  err;
        logic [XGE_MOD_W-1:0]  mod;
        logic [XGE_DATA_W-1:0] data;
    } xge_word_t;

    typedef enum logic {
        IDLE,
        READ
    } rx_rd_state_e;

    // Number of valid bytes carried by an eop word; a mod of 0 means a full word.
    function automatic logic [3:0] mod_to_bytes(input logic [XGE_MOD_W-1:0] mod);
        return (mod == '0) ? 4'd8 : {1'b0, mod};
    endfunction

endpackage

// File: rtl/xge_rx_reader_if.sv
// Bus interfaces of the receive reader: the MAC packet-read port and the
// outgoing valid/ready word stream.

interface xge_mac_rx_if;
    import xge_pkg::*;

    logic                  pkt_rx_avail;
    logic                  pkt_rx_ren;
    logic                  pkt_rx_val;
    logic                  pkt_rx_sop;
    logic                  pkt_rx_eop;
    logic                  pkt_rx_err;
    logic [XGE_MOD_W-1:0]  pkt_rx_mod;
    logic [XGE_DATA_W-1:0] pkt_rx_data;

    // The MAC side supplies words and availability, the reader issues read enables.
    modport master (
        output pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err,
               pkt_rx_mod, pkt_rx_data,
        input  pkt_rx_ren
    );

    modport slave (
        input  pkt_rx_avail, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err,
               pkt_rx_mod, pkt_rx_data,
        output pkt_rx_ren
    );
endinterface

interface xge_stream_if;
    import xge_pkg::*;

    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sop;
    logic                  out_eop;
    logic                  out_err;
    logic [XGE_MOD_W-1:0]  out_mod;
    logic [XGE_DATA_W-1:0] out_data;

    modport master (
        output out_valid, out_sop, out_eop, out_err, out_mod, out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_sop, out_eop, out_err, out_mod, out_data,
        output out_ready
    );
endinterface

// File: rtl/xge_rx_reader_sync_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head and a free-entry
// count, used to absorb the MAC's read latency.
module xge_sync_fifo
    import xge_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = xge_word_t
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  T                         i_data,
    input  logic                     i_pop,
    output T                         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              r_mem [DEPTH];
    logic [AW-1:0] r_rdPtr;
    logic [AW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_doPop;
    logic w_doPush;

    assign o_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_doPop  = i_pop && !o_empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_doPush = i_push && (!w_full || w_doPop);
    assign o_data   = r_mem[r_rdPtr];
    assign o_free   = CW'(DEPTH) - r_count;

    // Storage needs no reset; emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/xge_rx_reader.sv
// Receive-side packet reader: pulls packets out of the 10G MAC, checks their
// framing, re-presents them on a valid/ready stream and keeps statistics.
module xge_rx_reader
    import xge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_156m25,
    xge_mac_rx_if.slave      mac,
    xge_stream_if.master     strm,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] proto_err_cnt
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    rx_rd_state_e     r_state;
    rx_rd_state_e     w_nextState;
    logic             r_inPkt;
    logic [15:0]      r_wordCnt;

    xge_word_t        w_macWord;
    xge_word_t        w_head;
    logic             w_empty;
    logic [FCW-1:0]   w_free;
    logic             w_fwd;
    logic             w_protoErr;
    logic             w_eopFwd;
    logic [15:0]      w_wordsNow;
    logic [18:0]      w_pktBytes;

    assign w_macWord.sop  = mac.pkt_rx_sop;
    assign w_macWord.eop  = mac.pkt_rx_eop;
    assign w_macWord.err  = mac.pkt_rx_err;
    assign w_macWord.mod  = mac.pkt_rx_mod;
    assign w_macWord.data = mac.pkt_rx_data;

    // Reads are only issued with room for both the requested word and one in flight.
    assign mac.pkt_rx_ren = (r_state == READ) && (w_free >= FCW'(2));

    // A word is forwarded if it opens a packet or continues an open one.
    assign w_fwd      = mac.pkt_rx_val && (mac.pkt_rx_sop || r_inPkt);
    assign w_protoErr = mac.pkt_rx_val && (mac.pkt_rx_sop ? r_inPkt : !r_inPkt);
    assign w_eopFwd   = w_fwd && mac.pkt_rx_eop;
    assign w_wordsNow = mac.pkt_rx_sop      ? 16'd1 :
                        (&r_wordCnt)        ? r_wordCnt :
                                              r_wordCnt + 16'd1;
    assign w_pktBytes = {w_wordsNow - 16'd1, 3'b000} + {15'd0, mod_to_bytes(mac.pkt_rx_mod)};

    xge_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (xge_word_t)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (reset_156m25),
        .i_push  (w_fwd),
        .i_data  (w_macWord),
        .i_pop   (strm.out_ready),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_free  (w_free)
    );

    // Framing fields are forced to zero whenever no word is presented.
    assign strm.out_valid = !w_empty;
    assign strm.out_sop   = !w_empty && w_head.sop;
    assign strm.out_eop   = !w_empty && w_head.eop;
    assign strm.out_err   = !w_empty && w_head.err;
    assign strm.out_mod   = w_empty ? '0 : w_head.mod;
    assign strm.out_data  = w_empty ? '0 : w_head.data;

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset_156m25) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Start reading when the MAC has a packet; stop once its last word is captured.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (mac.pkt_rx_avail) w_nextState = READ;
            READ:    if (mac.pkt_rx_val && mac.pkt_rx_eop) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Framing tracker, per-packet word count and statistics, all updated on MAC capture.
    always_ff @(posedge clk) begin
        if (reset_156m25) begin
            r_inPkt       <= 1'b0;
            r_wordCnt     <= '0;
            pkt_cnt       <= '0;
            err_cnt       <= '0;
            byte_cnt      <= '0;
            proto_err_cnt <= '0;
        end else begin
            if (w_protoErr) begin
                proto_err_cnt <= proto_err_cnt + CNT_W'(1);
            end
            if (w_fwd) begin
                r_inPkt   <= !mac.pkt_rx_eop;
                r_wordCnt <= mac.pkt_rx_eop ? '0 : w_wordsNow;
            end
            if (w_eopFwd) begin
                if (mac.pkt_rx_err) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end else begin
                    pkt_cnt  <= pkt_cnt + CNT_W'(1);
                    byte_cnt <= byte_cnt + CNT_W'(w_pktBytes);
                end
            end
        end
    end

endmodule
